// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and WIDTH bounds.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the bit-serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/full_adder_cell.sv
// Combinational one-bit full adder used once by the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one registered full-adder step per clock, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] w_sum_sh_next;
  logic             r_carry;
  logic             r_c_msb;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  full_adder_cell u_fa (
    .a  (r_a_sh[0]),
    .b  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
  assign w_last   = (r_state == ST_BUSY) && (r_cnt == CntW'(WIDTH - 1));

  // Shift the new sum bit in at the MSB end; written this way so WIDTH=1 needs no slicing.
  always_comb begin
    w_sum_sh_next            = r_sum_sh >> 1;
    w_sum_sh_next[WIDTH-1]   = w_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_next = ST_BUSY;
      ST_BUSY: if (w_last)        w_state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: bus.in_ready  = 1'b1;
      ST_DONE: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on accept, one bit per BUSY cycle, publish result on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_c_msb  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == ST_BUSY) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_sh_next;
      r_carry  <= w_co;
      r_cnt    <= r_cnt + CntW'(1);
      if (w_last) begin
        // r_carry here is the carry into the MSB.
        r_c_msb <= r_carry;
        r_sum   <= w_sum_sh_next;
        r_cout  <= w_co;
      end
    end
  end

  // Result registers hold through DONE and IDLE until the next result.
  always_comb begin
    bus.sum  = r_sum;
    bus.cout = r_cout;
    bus.ovf  = r_c_msb ^ r_cout;
  end

endmodule
